// File: rtl/fir_engine.sv
// Streaming FIR engine: AXI-Stream in/out, taps and sample history held in external BRAMs.
// One sample is processed at a time; each output takes Tape_Num+2 cycles after its input handshake.
module fir_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic                   ss_tlast,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic                   sm_tlast,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pDATA_WIDTH-1:0] data_Di,
  output logic [pADDR_WIDTH-1:0] data_A,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam int CNT_W = $clog2(Tape_Num + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(Tape_Num - 1);
  localparam logic [CNT_W-1:0] TAPS     = CNT_W'(Tape_Num);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    WAIT_IN = 3'd2,
    MAC     = 3'd3,
    OUT     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                         state_q, state_d;
  logic        [CNT_W-1:0]        clr_idx_q, clr_idx_d;
  logic        [CNT_W-1:0]        wp_q, wp_d;
  logic        [CNT_W-1:0]        k_q, k_d;
  logic        [CNT_W-1:0]        rd_idx_q, rd_idx_d;
  logic                           mac_vld_q, mac_vld_d;
  logic signed [pDATA_WIDTH-1:0]  acc_q, acc_d;
  logic        [31:0]             cnt_q, cnt_d;
  logic        [31:0]             len_q, len_d;
  logic                           last_q, last_d;

  // Product keeps only its low word; the running sum wraps freely.
  function automatic logic signed [pDATA_WIDTH-1:0] mac_wrap(
    input logic signed [pDATA_WIDTH-1:0] acc,
    input logic signed [pDATA_WIDTH-1:0] a,
    input logic signed [pDATA_WIDTH-1:0] b
  );
    logic signed [2*pDATA_WIDTH-1:0] prod;
    prod = a * b;
    return acc + $signed(prod[pDATA_WIDTH-1:0]);
  endfunction

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [CNT_W-1:0] idx);
    return pADDR_WIDTH'({idx, 2'b00});
  endfunction

  function automatic logic [CNT_W-1:0] idx_inc(input logic [CNT_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] idx_dec(input logic [CNT_W-1:0] idx);
    return (idx == '0) ? LAST_IDX : idx - CNT_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wp_d      = wp_q;
    k_d       = k_q;
    rd_idx_d  = rd_idx_q;
    mac_vld_d = 1'b0;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    last_d    = last_q;
    ss_tready = 1'b0;
    tap_EN    = 1'b0;
    tap_A     = '0;
    data_EN   = 1'b0;
    data_WE   = 4'h0;
    data_A    = '0;
    data_Di   = '0;

    // BRAM data returns one cycle after the read, so accumulate on the delayed valid.
    if (mac_vld_q) acc_d = mac_wrap(acc_q, tap_Do, data_Do);

    unique case (state_q)
      IDLE: begin
        if (ap_start && (data_length != 32'd0)) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          len_d     = data_length;
          cnt_d     = '0;
        end
      end
      CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hf;
        data_A  = word_addr(clr_idx_q);
        if (clr_idx_q == LAST_IDX) begin
          state_d = WAIT_IN;
          wp_d    = '0;
        end else begin
          clr_idx_d = clr_idx_q + CNT_W'(1);
        end
      end
      WAIT_IN: begin
        ss_tready = 1'b1;
        data_A    = word_addr(wp_q);
        if (ss_tvalid) begin
          data_EN  = 1'b1;
          data_WE  = 4'hf;
          data_Di  = ss_tdata;
          state_d  = MAC;
          k_d      = '0;
          rd_idx_d = wp_q;
          acc_d    = '0;
          cnt_d    = cnt_q + 32'd1;
          last_d   = ((cnt_q + 32'd1) == len_q) || ss_tlast;
        end
      end
      MAC: begin
        // Tape_Num read cycles followed by one drain cycle for the final product.
        if (k_q != TAPS) begin
          tap_EN    = 1'b1;
          tap_A     = word_addr(k_q);
          data_EN   = 1'b1;
          data_A    = word_addr(rd_idx_q);
          mac_vld_d = 1'b1;
          k_d       = k_q + CNT_W'(1);
          rd_idx_d  = idx_dec(rd_idx_q);
        end else begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (sm_tready) begin
          wp_d    = idx_inc(wp_q);
          state_d = last_q ? DONE : WAIT_IN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      wp_q      <= '0;
      k_q       <= '0;
      rd_idx_q  <= '0;
      mac_vld_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wp_q      <= wp_d;
      k_q       <= k_d;
      rd_idx_q  <= rd_idx_d;
      mac_vld_q <= mac_vld_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      last_q    <= last_d;
    end
  end

  assign ap_idle   = (state_q == IDLE);
  assign ap_done   = (state_q == DONE);
  assign sm_tvalid = (state_q == OUT);
  assign sm_tlast  = (state_q == OUT) && last_q;
  assign sm_tdata  = acc_q;

endmodule

// File: tb/tb_fir_engine.sv
// Bench for fir_engine: BRAM models, randomized streams, queue-based scoreboard fed by a
// convolution reference model.
module tb_fir_engine;

  localparam int N = 11;

  logic        clk = 1'b0;
  logic        axis_rst, ap_start, ap_idle, ap_done;
  logic [31:0] data_length;
  logic [31:0] ss_tdata, sm_tdata;
  logic        ss_tvalid, ss_tready, ss_tlast;
  logic        sm_tvalid, sm_tready, sm_tlast;
  logic        tap_EN, data_EN;
  logic [11:0] tap_A, data_A;
  logic [31:0] tap_Do, data_Di, data_Do;
  logic [3:0]  data_WE;

  always #5 clk = ~clk;

  fir_engine #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(N)) dut (
    .axis_clk(clk), .axis_rst(axis_rst), .ap_start(ap_start), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done),
    .ss_tdata(ss_tdata), .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tlast(ss_tlast),
    .sm_tdata(sm_tdata), .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .tap_EN(tap_EN), .tap_A(tap_A), .tap_Do(tap_Do),
    .data_WE(data_WE), .data_EN(data_EN), .data_Di(data_Di), .data_A(data_A), .data_Do(data_Do)
  );

  logic [31:0] tap_mem  [0:1023];
  logic [31:0] data_mem [0:1023];

  always @(posedge clk) begin
    if (tap_EN) tap_Do <= tap_mem[tap_A[11:2]];
    if (data_EN) begin
      for (int b = 0; b < 4; b++)
        if (data_WE[b]) data_mem[data_A[11:2]][8*b +: 8] <= data_Di[8*b +: 8];
      data_Do <= data_mem[data_A[11:2]];
    end
  end

  typedef struct { logic [31:0] d; logic l; } exp_t;
  exp_t        exp_q[$];
  int          hs_q[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, done_cnt = 0;
  logic [31:0] last_rx = '0;
  logic [31:0] stim [0:31];
  bit          stall_req = 0, bp_random = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++; n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!axis_rst && sm_tvalid && sm_tready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_unexpected: got output %0h, expected none", sm_tdata);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", sm_tdata, e.d);
          check("sb_last", {31'd0, sm_tlast}, {31'd0, e.l});
          last_rx = sm_tdata;
        end
      end
    end
  end

  // Input-to-output latency and ap_done pulse width
  initial begin
    logic prev_v, prev_done;
    prev_v = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (axis_rst) begin
        hs_q.delete();
        prev_v = 0;
      end else begin
        if (ss_tvalid && ss_tready) hs_q.push_back(cyc);
        if (sm_tvalid && !prev_v) begin
          if (hs_q.size() == 0) check("lat_no_input", 32'd1, 32'd0);
          else check("latency", cyc - hs_q.pop_front(), N + 2);
        end
        prev_v = sm_tvalid;
      end
      if (ap_done) begin
        check("done_width", {31'd0, prev_done}, 32'd0);
        done_cnt++;
      end
      prev_done = ap_done;
    end
  end

  // Output backpressure, including one directed 5-cycle stall
  initial begin
    logic [31:0] held;
    sm_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_req && sm_tvalid) begin
        stall_req = 0;
        sm_tready = 1'b0;
        held = sm_tdata;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_valid", {31'd0, sm_tvalid}, 32'd1);
          check("stall_data", sm_tdata, held);
          check("stall_ss_tready", {31'd0, ss_tready}, 32'd0);
          @(posedge clk); #1;
        end
        sm_tready = 1'b1;
      end else begin
        sm_tready = bp_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_idle"}, {31'd0, ap_idle}, 32'd1);
    check({tag, "_done"}, {31'd0, ap_done}, 32'd0);
    check({tag, "_ss_tready"}, {31'd0, ss_tready}, 32'd0);
    check({tag, "_sm_tvalid"}, {31'd0, sm_tvalid}, 32'd0);
    check({tag, "_sm_tlast"}, {31'd0, sm_tlast}, 32'd0);
    check({tag, "_en"}, {30'd0, tap_EN, data_EN}, 32'd0);
    check({tag, "_we"}, {28'd0, data_WE}, 32'd0);
    check({tag, "_addr"}, {8'd0, tap_A, data_A}, 32'd0);
    check({tag, "_di"}, data_Di, 32'd0);
    check({tag, "_sm_tdata"}, sm_tdata, 32'd0);
  endtask

  // Drive one run; the expected output of every accepted sample is plain convolution
  // of the taps with the samples of this run (history before the run is zero).
  task automatic do_run(input int len, input int nsend, input int tlast_at, input bit gaps);
    logic signed [31:0] hist[$];
    logic signed [31:0] y;
    int w;
    exp_t e;
    @(posedge clk); #1;
    ap_start = 1; data_length = len;
    ss_tvalid = 1; ss_tdata = stim[0]; ss_tlast = (tlast_at == 1);
    @(negedge clk);
    check("start_no_accept", {31'd0, ss_tready}, 32'd0);
    @(posedge clk); #1;
    ap_start = 0;
    @(negedge clk);
    check("idle_low_after_start", {31'd0, ap_idle}, 32'd0);
    for (int i = 0; i < nsend; i++) begin
      if (i > 0) begin
        if (gaps) begin
          ss_tvalid = 0;
          if (i == 2) begin
            ap_start = 1; @(posedge clk); #1; ap_start = 0;
          end
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        ss_tvalid = 1; ss_tdata = stim[i]; ss_tlast = (tlast_at == i + 1);
      end
      w = 0;
      forever begin
        @(negedge clk);
        if (ss_tready) break;
        if (++w > 200) timeout("ss_handshake");
      end
      hist.push_back(ss_tdata);
      y = 0;
      for (int k = 0; k < N && k < hist.size(); k++)
        y = y + $signed(tap_mem[k]) * hist[hist.size() - 1 - k];
      e.d = y;
      e.l = (i + 1 == len) || (tlast_at == i + 1);
      exp_q.push_back(e);
      @(posedge clk); #1;
      ss_tvalid = 0; ss_tlast = 0;
    end
    w = 0;
    forever begin
      @(negedge clk);
      if (ap_done) break;
      if (++w > 2000) timeout("ap_done");
    end
    check("all_outputs_seen", exp_q.size(), 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, ap_done}, 32'd0);
    check("idle_after_done", {31'd0, ap_idle}, 32'd1);
  endtask

  task automatic rand_taps();
    for (int k = 0; k < N; k++)
      tap_mem[k] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
  endtask

  initial begin
    int len, tl, nsend, w, done_before;
    logic [31:0] want;
    int ir_taps [0:N-1] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    for (int i = 0; i < 1024; i++) begin tap_mem[i] = '0; data_mem[i] = $urandom; end
    axis_rst = 1; ap_start = 0; data_length = 0; ss_tdata = 0; ss_tvalid = 0; ss_tlast = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    axis_rst = 0;

    // ap_start with zero length is ignored
    ap_start = 1; data_length = 0;
    @(posedge clk); #1;
    ap_start = 0;
    repeat (2) @(negedge clk);
    check("zero_len_idle", {31'd0, ap_idle}, 32'd1);

    // Impulse response reproduces the taps
    for (int k = 0; k < N; k++) tap_mem[k] = ir_taps[k];
    for (int i = 0; i < 32; i++) stim[i] = (i == 0) ? 32'd1 : 32'd0;
    do_run(11, 11, 0, 0);
    check("impulse_last_out", last_rx, 32'd0);

    // All-ones taps give a running sum
    for (int k = 0; k < N; k++) tap_mem[k] = 32'd1;
    stim[0] = 1; stim[1] = 2; stim[2] = 3;
    do_run(3, 3, 0, 0);
    check("running_sum_last", last_rx, 32'd6);

    // Output stall
    rand_taps();
    for (int i = 0; i < 32; i++) stim[i] = $urandom;
    stall_req = 1;
    do_run(4, 4, 0, 0);
    check("stall_happened", {31'd0, stall_req}, 32'd0);

    // Early ss_tlast ends the run
    for (int i = 0; i < 32; i++) stim[i] = 32'($urandom_range(0, 2000)) - 32'd1000;
    do_run(10, 4, 4, 0);
    repeat (3) @(negedge clk);
    check("early_last_idle", {31'd0, ap_idle}, 32'd1);
    check("early_last_no_ready", {31'd0, ss_tready}, 32'd0);

    // Reset in the middle of MAC
    rand_taps();
    @(posedge clk); #1;
    ap_start = 1; data_length = 5; ss_tvalid = 1; ss_tdata = $urandom; ss_tlast = 0;
    @(posedge clk); #1;
    ap_start = 0;
    w = 0;
    forever begin @(negedge clk); if (ss_tready) break; if (++w > 200) timeout("rst_hs"); end
    @(posedge clk); #1;
    ss_tvalid = 0;
    w = 0;
    forever begin @(negedge clk); if (tap_EN) break; if (++w > 50) timeout("rst_mac"); end
    @(posedge clk); #1;
    axis_rst = 1;
    done_before = done_cnt;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    axis_rst = 0;
    exp_q.delete();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", done_cnt, done_before);
    rand_taps();
    stim[0] = 32'd5;
    do_run(1, 1, 0, 0);
    want = 32'd5 * tap_mem[0];
    check("rst_first_out", last_rx, want);

    // Randomized runs with input gaps and output backpressure
    bp_random = 1;
    for (int r = 0; r < 6; r++) begin
      rand_taps();
      for (int i = 0; i < 32; i++) stim[i] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 20)) - 32'd10;
      len = $urandom_range(1, 24);
      tl  = $urandom_range(0, 2) == 0 ? $urandom_range(1, 24) : 0;
      nsend = (tl > 0 && tl < len) ? tl : len;
      do_run(len, nsend, tl, 1);
    end
    bp_random = 0;

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_engine.md
FIR_ENGINE -- requirements
Module: fir_engine

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, meaning BRAM address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, meaning sample, tap and result width.
REQ-003 SHALL have parameter Tape_Num, default 11, meaning number of taps and history depth.
REQ-004 SHALL have axis_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have axis_rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have ap_start, input, 1, a start pulse from the config block.
REQ-007 SHALL have data_length, input, 32, the number of samples per run, sampled when ap_start is accepted.
REQ-008 SHALL have ap_idle, output, 1, and ap_done, output, 1, for engine status.
REQ-009 SHALL have ss_tdata (input, pDATA_WIDTH), ss_tvalid (input, 1), ss_tready (output, 1) and ss_tlast (input, 1) as the AXI-Stream sample input.
REQ-010 SHALL have sm_tdata (output, pDATA_WIDTH), sm_tvalid (output, 1), sm_tready (input, 1) and sm_tlast (output, 1) as the AXI-Stream result output.
REQ-011 SHALL have tap_EN (output, 1), tap_A (output, pADDR_WIDTH) and tap_Do (input, pDATA_WIDTH) for read-only access to the tap BRAM.
REQ-012 SHALL have data_WE (output, 4), data_EN (output, 1), data_Di (output, pDATA_WIDTH), data_A (output, pADDR_WIDTH) and data_Do (input, pDATA_WIDTH) for the history BRAM.

Function
REQ-013 SHALL use byte addresses on both BRAMs: word i is at address 4*i, and the BRAM read latency is 1 cycle.
REQ-014 SHALL implement the FSM states IDLE, CLEAR, WAIT_IN, MAC, OUT and DONE.
REQ-015 IDLE SHALL go to CLEAR on ap_start=1 with data_length!=0; otherwise ap_start is ignored, including whenever the FSM is not in IDLE.
REQ-016 CLEAR SHALL write 0 to data words 0..Tape_Num-1, one word per cycle with data_WE=4'hf, reset the write pointer wp to 0, then go to WAIT_IN.
REQ-017 WAIT_IN SHALL hold ss_tready=1 and ss_tready SHALL be 0 in every other state.
REQ-018 On an ss handshake, the same cycle SHALL write ss_tdata to data word wp and the FSM SHALL go to MAC.
REQ-019 MAC SHALL, for k=0..Tape_Num-1, read tap word k and data word (wp-k) mod Tape_Num, then form acc = sum of tap[k]*x[k].
REQ-020 Each product SHALL be a signed pDATA_WIDTH x pDATA_WIDTH multiply truncated to its low pDATA_WIDTH bits, and the accumulator SHALL wrap modulo 2^pDATA_WIDTH without saturation.
REQ-021 sm_tvalid SHALL rise exactly Tape_Num+2 cycles after the ss handshake cycle.
REQ-022 In OUT, sm_tdata=acc and sm_tlast SHALL stay stable while sm_tvalid=1 and sm_tready=0.
REQ-023 wp SHALL advance as wp+1, wrapping Tape_Num-1 -> 0, on each sm handshake.
REQ-024 A sample SHALL be last when its 1-based index equals data_length or when ss_tlast=1 at acceptance, whichever comes first; an early ss_tlast terminates the run.
REQ-025 sm_tlast SHALL be 1 only on the output of the last sample.
REQ-026 On an sm handshake, OUT SHALL go to DONE if the sample was last, else to WAIT_IN.
REQ-027 DONE SHALL pulse ap_done=1 for exactly one cycle and then go to IDLE.
REQ-028 ap_idle SHALL be 1 only in IDLE, and SHALL go to 0 the cycle after ap_start is accepted.
REQ-029 tap_EN SHALL be 1 only in MAC, and data_EN SHALL be 1 only during CLEAR, the sample write and MAC reads; data_WE SHALL be 4'h0 outside CLEAR and the sample write.
REQ-030 A simultaneous ss_tvalid and ap_start in IDLE SHALL not accept the sample; samples are accepted only in WAIT_IN.

Reset
REQ-031 While axis_rst=1 at a clock edge, the FSM SHALL go to IDLE, with ap_idle=1 and ap_done=0.
REQ-032 The same reset SHALL force ss_tready, sm_tvalid, sm_tlast, tap_EN and data_EN to 0, data_WE to 0, and all addresses, data_Di, sm_tdata, acc, wp and the sample counter to 0.
REQ-033 A reset asserted mid-run, in any state, SHALL abort the run with no ap_done pulse; the next run starts with CLEAR.

Verification
REQ-034 Bench SHALL cover: taps {0,-10,-9,23,56,63,56,23,-9,-10,0}, data_length=11, input 1,0,0,...,0 -> outputs equal the taps in order, with sm_tlast only on output 11.
REQ-035 Bench SHALL cover: all taps=1, data_length=3, input 1,2,3 -> outputs 1,3,6, then a one-cycle ap_done and ap_idle=1.
REQ-036 Bench SHALL cover: sm_tready held 0 for 5 cycles with sm_tvalid=1 -> sm_tdata stable, ss_tready=0 throughout, and no lost sample.
REQ-037 Bench SHALL cover: data_length=10 with ss_tlast on sample 4 -> exactly 4 outputs, sm_tlast on output 4, then ap_done.
REQ-038 Bench SHALL cover: axis_rst pulsed during MAC, then a new run with taps h and input 5 -> first output 5*h[0], showing no stale history and no ap_done from the aborted run.
REQ-039 Bench SHALL cover: every ss handshake -> sm_tvalid rises exactly 13 cycles later (Tape_Num=11).
